// File: rtl/axil_demux_if.sv
// AXI-Lite channel bundle used by the demux host port and its
// downstream ports.
interface axil_demux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awValid;
  logic              awReady;
  logic [ADDR_W-1:0] awAddr;
  logic [2:0]        awProt;
  logic              wValid;
  logic              wReady;
  logic [DATA_W-1:0] wData;
  logic [DATA_W/8-1:0] wStrb;
  logic              bValid;
  logic              bReady;
  logic [1:0]        bResp;
  logic              arValid;
  logic              arReady;
  logic [ADDR_W-1:0] arAddr;
  logic [2:0]        arProt;
  logic              rValid;
  logic              rReady;
  logic [DATA_W-1:0] rData;
  logic [1:0]        rResp;

  modport master (
    output awValid, awAddr, awProt,
    output wValid, wData, wStrb,
    output bReady, arValid, arAddr,
    output arProt, rReady,
    input  awReady, wReady, bValid,
    input  bResp, arReady, rValid,
    input  rData, rResp
  );

  modport slave (
    input  awValid, awAddr, awProt,
    input  wValid, wData, wStrb,
    input  bReady, arValid, arAddr,
    input  arProt, rReady,
    output awReady, wReady, bValid,
    output bResp, arReady, rValid,
    output rData, rResp
  );
endinterface

// File: rtl/axil_demux.sv
// AXI-Lite 1:N address demux, one outstanding write and one read,
// independent paths, all outputs registered.
module axil_demux #(
  parameter int                SLAVES = 4,
  parameter int                SLOT_W = 12,
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input logic          clk,
  input logic          rstn,
  axil_demux_if.slave  s,
  axil_demux_if.master m [SLAVES]
);
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int SB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] MASK =
    {ADDR_W{1'b1}} >> (ADDR_W - SLOT_W);

  if (SLAVES < 1 || SLAVES > 16) begin : g_bad_slaves
    $fatal(1, "axil_demux: SLAVES out of range 1..16");
  end
  if (SLOT_W < 2) begin : g_bad_slot
    $fatal(1, "axil_demux: SLOT_W must be >= 2");
  end
  if ((BASE & MASK) != '0) begin : g_bad_base
    $fatal(1, "axil_demux: BASE not slot aligned");
  end

  typedef logic [SLAVES-1:0] oh_t;
  typedef enum logic [2:0] {
    W_IDLE, W_DATA, W_FWD, W_BWAIT, W_RESP
  } wst_t;
  typedef enum logic [1:0] {
    R_IDLE, R_FWD, R_WAIT, R_RESP
  } rdst_t;

  // address decode, shared shape for both paths
  logic [ADDR_W-1:0] aw_slot, ar_slot;
  logic              aw_err, ar_err;
  assign aw_slot = (s.awAddr - BASE) >> SLOT_W;
  assign ar_slot = (s.arAddr - BASE) >> SLOT_W;
  assign aw_err  = (s.awAddr < BASE) ||
                   (aw_slot >= ADDR_W'(SLAVES));
  assign ar_err  = (s.arAddr < BASE) ||
                   (ar_slot >= ADDR_W'(SLAVES));

  wst_t              w_st, w_st_n;
  logic [SW-1:0]     w_sel_q, w_sel_n;
  logic              w_err_q, w_err_n;
  logic [ADDR_W-1:0] wa_q, wa_n;
  logic [2:0]        wp_q, wp_n;
  logic [DATA_W-1:0] wd_q, wd_n;
  logic [SB-1:0]     ws_q, ws_n;
  oh_t               aw_v_q, aw_v_n, w_v_q, w_v_n;
  oh_t               b_r_q, b_r_n;
  logic              awr_q, awr_n, wr_q, wr_n;
  logic              bv_q, bv_n;
  logic [1:0]        br_q, br_n;

  rdst_t             r_st, r_st_n;
  logic [SW-1:0]     r_sel_q, r_sel_n;
  logic [ADDR_W-1:0] ra_q, ra_n;
  logic [2:0]        rp_q, rp_n;
  oh_t               ar_v_q, ar_v_n, r_r_q, r_r_n;
  logic              arr_q, arr_n, rv_q, rv_n;
  logic [1:0]        rr_q, rr_n;
  logic [DATA_W-1:0] rd_q, rd_n;

  oh_t               m_awr, m_wr, m_bv, m_arr, m_rv;
  logic [1:0]        m_br [SLAVES];
  logic [1:0]        m_rr [SLAVES];
  logic [DATA_W-1:0] m_rd [SLAVES];

  for (genvar i = 0; i < SLAVES; i++) begin : g_port
    assign m[i].awValid = aw_v_q[i];
    assign m[i].awAddr  = wa_q;
    assign m[i].awProt  = wp_q;
    assign m[i].wValid  = w_v_q[i];
    assign m[i].wData   = wd_q;
    assign m[i].wStrb   = ws_q;
    assign m[i].bReady  = b_r_q[i];
    assign m[i].arValid = ar_v_q[i];
    assign m[i].arAddr  = ra_q;
    assign m[i].arProt  = rp_q;
    assign m[i].rReady  = r_r_q[i];
    assign m_awr[i] = m[i].awReady;
    assign m_wr[i]  = m[i].wReady;
    assign m_bv[i]  = m[i].bValid;
    assign m_br[i]  = m[i].bResp;
    assign m_arr[i] = m[i].arReady;
    assign m_rv[i]  = m[i].rValid;
    assign m_rd[i]  = m[i].rData;
    assign m_rr[i]  = m[i].rResp;
  end

  assign s.awReady = awr_q;
  assign s.wReady  = wr_q;
  assign s.bValid  = bv_q;
  assign s.bResp   = br_q;
  assign s.arReady = arr_q;
  assign s.rValid  = rv_q;
  assign s.rData   = rd_q;
  assign s.rResp   = rr_q;

  logic aw_done, w_done;

  always_comb begin
    w_st_n = w_st; w_sel_n = w_sel_q;
    w_err_n = w_err_q; wa_n = wa_q;
    wp_n = wp_q; wd_n = wd_q; ws_n = ws_q;
    aw_v_n = aw_v_q; w_v_n = w_v_q;
    b_r_n = b_r_q; awr_n = awr_q;
    wr_n = wr_q; bv_n = bv_q; br_n = br_q;
    aw_done = !aw_v_q[w_sel_q] || m_awr[w_sel_q];
    w_done  = !w_v_q[w_sel_q] || m_wr[w_sel_q];
    unique case (w_st)
      W_IDLE: begin
        awr_n = 1'b1;
        if (awr_q && s.awValid) begin
          awr_n = 1'b0; wr_n = 1'b1;
          w_sel_n = aw_slot[SW-1:0];
          w_err_n = aw_err;
          wa_n = s.awAddr & MASK;
          wp_n = s.awProt;
          w_st_n = W_DATA;
        end
      end
      W_DATA: if (wr_q && s.wValid) begin
        wr_n = 1'b0; wd_n = s.wData; ws_n = s.wStrb;
        if (w_err_q) begin
          br_n = 2'b11; bv_n = 1'b1; w_st_n = W_RESP;
        end else begin
          aw_v_n = oh_t'(1) << w_sel_q;
          w_v_n  = oh_t'(1) << w_sel_q;
          w_st_n = W_FWD;
        end
      end
      W_FWD: begin
        // AW and W retire independently; wait for both
        if (aw_done) aw_v_n = '0;
        if (w_done) w_v_n = '0;
        if (aw_done && w_done) begin
          b_r_n = oh_t'(1) << w_sel_q;
          w_st_n = W_BWAIT;
        end
      end
      W_BWAIT: if (m_bv[w_sel_q]) begin
        br_n = m_br[w_sel_q]; b_r_n = '0;
        bv_n = 1'b1; w_st_n = W_RESP;
      end
      W_RESP: if (s.bReady) begin
        bv_n = 1'b0; awr_n = 1'b1; w_st_n = W_IDLE;
      end
      default: w_st_n = W_IDLE;
    endcase
  end

  always_comb begin
    r_st_n = r_st; r_sel_n = r_sel_q;
    ra_n = ra_q; rp_n = rp_q;
    ar_v_n = ar_v_q; r_r_n = r_r_q;
    arr_n = arr_q; rv_n = rv_q;
    rr_n = rr_q; rd_n = rd_q;
    unique case (r_st)
      R_IDLE: begin
        arr_n = 1'b1;
        if (arr_q && s.arValid) begin
          arr_n = 1'b0;
          r_sel_n = ar_slot[SW-1:0];
          ra_n = s.arAddr & MASK;
          rp_n = s.arProt;
          if (ar_err) begin
            rd_n = '0; rr_n = 2'b11;
            rv_n = 1'b1; r_st_n = R_RESP;
          end else begin
            ar_v_n = oh_t'(1) << ar_slot[SW-1:0];
            r_st_n = R_FWD;
          end
        end
      end
      R_FWD: if (m_arr[r_sel_q]) begin
        ar_v_n = '0;
        r_r_n = oh_t'(1) << r_sel_q;
        r_st_n = R_WAIT;
      end
      R_WAIT: if (m_rv[r_sel_q]) begin
        rd_n = m_rd[r_sel_q]; rr_n = m_rr[r_sel_q];
        r_r_n = '0; rv_n = 1'b1; r_st_n = R_RESP;
      end
      R_RESP: if (s.rReady) begin
        rv_n = 1'b0; arr_n = 1'b1; r_st_n = R_IDLE;
      end
      default: r_st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_st <= W_IDLE; w_sel_q <= '0; w_err_q <= 1'b0;
      wa_q <= '0; wp_q <= '0; wd_q <= '0; ws_q <= '0;
      aw_v_q <= '0; w_v_q <= '0; b_r_q <= '0;
      awr_q <= 1'b0; wr_q <= 1'b0;
      bv_q <= 1'b0; br_q <= 2'b00;
      r_st <= R_IDLE; r_sel_q <= '0;
      ra_q <= '0; rp_q <= '0;
      ar_v_q <= '0; r_r_q <= '0;
      arr_q <= 1'b0; rv_q <= 1'b0;
      rr_q <= 2'b00; rd_q <= '0;
    end else begin
      w_st <= w_st_n; w_sel_q <= w_sel_n;
      w_err_q <= w_err_n; wa_q <= wa_n;
      wp_q <= wp_n; wd_q <= wd_n; ws_q <= ws_n;
      aw_v_q <= aw_v_n; w_v_q <= w_v_n;
      b_r_q <= b_r_n; awr_q <= awr_n;
      wr_q <= wr_n; bv_q <= bv_n; br_q <= br_n;
      r_st <= r_st_n; r_sel_q <= r_sel_n;
      ra_q <= ra_n; rp_q <= rp_n;
      ar_v_q <= ar_v_n; r_r_q <= r_r_n;
      arr_q <= arr_n; rv_q <= rv_n;
      rr_q <= rr_n; rd_q <= rd_n;
    end
  end
endmodule

// File: tb/tb_axil_demux.sv
// Directed bench for axil_demux: vector table plus hand-written
// sequences for stalls, back-pressure and mid-transaction reset.
module tb_axil_demux;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axil_demux_if s_if ();
  axil_demux_if mif [4] ();

  axil_demux #(
    .SLAVES(4), .SLOT_W(12), .BASE(32'h0)
  ) dut (
    .clk(clk), .rstn(rstn), .s(s_if), .m(mif)
  );

  int checks = 0;
  int failures = 0;

  int         aw_dly [4]  = '{0, 0, 0, 0};
  bit         hold_b [4]  = '{0, 0, 0, 0};
  logic [1:0] wr_resp [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
  logic [1:0] rd_resp [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
  logic [31:0] rd_val [4] = '{32'hC0DE0000, 32'h11111111,
                              32'h12345678, 32'h33333333};

  logic [31:0] aw_seen [4];
  logic [31:0] w_seen [4];
  logic [3:0]  ws_seen [4];
  logic [2:0]  awp_seen [4];
  logic [31:0] ar_seen [4];
  logic [2:0]  arp_seen [4];
  int          act [4];
  int          viol [4];
  logic [3:0][4:0] pv;
  logic [3:0][1:0] prdy;

  // simple zero-wait downstream slaves with a tunable AW stall
  for (genvar i = 0; i < 4; i++) begin : g_sl
    int awc = 0;
    int ac = 0;
    int vl = 0;
    logic awg = 1'b0, wg = 1'b0;
    logic ahs, whs, a, w;
    logic [31:0] awa, wd, ara;
    logic [3:0] wsb;
    logic [2:0] awp, arp;
    logic [4:0] ppv = '0;
    logic [31:0] paa, pwd, par;
    logic pawr, pwr;

    assign mif[i].awReady = (awc >= aw_dly[i]);
    assign mif[i].wReady  = 1'b1;
    assign mif[i].arReady = 1'b1;
    assign ahs = mif[i].awValid && mif[i].awReady;
    assign whs = mif[i].wValid && mif[i].wReady;
    assign a = awg || ahs;
    assign w = wg || whs;
    assign pv[i] = {mif[i].awValid, mif[i].wValid,
                    mif[i].bReady, mif[i].arValid,
                    mif[i].rReady};
    assign prdy[i] = {mif[i].awReady, mif[i].wReady};
    assign aw_seen[i] = awa;
    assign w_seen[i] = wd;
    assign ws_seen[i] = wsb;
    assign awp_seen[i] = awp;
    assign ar_seen[i] = ara;
    assign arp_seen[i] = arp;
    assign act[i] = ac;
    assign viol[i] = vl;

    always @(posedge clk) begin
      if (!rstn) begin
        awc <= 0; awg <= 1'b0; wg <= 1'b0;
        mif[i].bValid <= 1'b0; mif[i].bResp <= 2'b00;
        mif[i].rValid <= 1'b0; mif[i].rData <= '0;
        mif[i].rResp <= 2'b00;
      end else begin
        if (|pv[i]) ac <= ac + 1;
        if (mif[i].awValid && !mif[i].awReady) awc <= awc + 1;
        else awc <= 0;
        if (ahs) begin
          awa <= mif[i].awAddr; awp <= mif[i].awProt;
        end
        if (whs) begin
          wd <= mif[i].wData; wsb <= mif[i].wStrb;
        end
        if (a && w && !mif[i].bValid && !hold_b[i]) begin
          mif[i].bValid <= 1'b1; mif[i].bResp <= wr_resp[i];
          awg <= 1'b0; wg <= 1'b0;
        end else begin
          awg <= a; wg <= w;
          if (mif[i].bValid && mif[i].bReady)
            mif[i].bValid <= 1'b0;
        end
        if (mif[i].arValid && mif[i].arReady) begin
          ara <= mif[i].arAddr; arp <= mif[i].arProt;
          mif[i].rValid <= 1'b1; mif[i].rData <= rd_val[i];
          mif[i].rResp <= rd_resp[i];
        end else if (mif[i].rValid && mif[i].rReady) begin
          mif[i].rValid <= 1'b0;
        end
      end
    end

    // demux-driven valids must hold with stable payload until accepted
    always @(negedge clk) begin
      if (!rstn) begin
        ppv <= '0;
      end else begin
        if (ppv[4] && !pawr && (!mif[i].awValid ||
            mif[i].awAddr != paa)) vl <= vl + 1;
        if (ppv[3] && !pwr && (!mif[i].wValid ||
            mif[i].wData != pwd)) vl <= vl + 1;
        if (ppv[1] && !mif[i].arReady && (!mif[i].arValid ||
            mif[i].arAddr != par)) vl <= vl + 1;
        ppv <= pv[i];
        paa <= mif[i].awAddr; pwd <= mif[i].wData;
        par <= mif[i].arAddr;
        pawr <= mif[i].awReady; pwr <= mif[i].wReady;
      end
    end
  end

  int viol_s = 0;
  logic pbv = 1'b0, pbr, prv = 1'b0, prr;
  logic [1:0] pbresp, prresp;
  logic [31:0] prdata;
  always @(negedge clk) begin
    if (!rstn) begin
      pbv <= 1'b0; prv <= 1'b0;
    end else begin
      if (pbv && !pbr && (!s_if.bValid ||
          s_if.bResp != pbresp)) viol_s <= viol_s + 1;
      if (prv && !prr && (!s_if.rValid || s_if.rResp != prresp ||
          s_if.rData != prdata)) viol_s <= viol_s + 1;
      pbv <= s_if.bValid; pbr <= s_if.bReady;
      pbresp <= s_if.bResp;
      prv <= s_if.rValid; prr <= s_if.rReady;
      prresp <= s_if.rResp; prdata <= s_if.rData;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  task automatic host_aw_w(input logic [31:0] ad, input logic [31:0] d,
                           input logic [3:0] st, output int n);
    bit awd, wdn;
    int g;
    awd = 0; wdn = 0; g = 0; n = 0;
    @(negedge clk);
    s_if.awValid = 1'b1; s_if.awAddr = ad; s_if.awProt = 3'b010;
    s_if.wValid = 1'b1; s_if.wData = d; s_if.wStrb = st;
    while (!(awd && wdn) && g < 100) begin
      if (s_if.awValid && s_if.awReady) awd = 1;
      if (s_if.wValid && s_if.wReady) wdn = 1;
      @(negedge clk);
      g++;
      if (awd) begin n++; s_if.awValid = 1'b0; end
      if (wdn) s_if.wValid = 1'b0;
    end
    if (g >= 100) begin
      tmo("aw_w");
      s_if.awValid = 1'b0; s_if.wValid = 1'b0;
    end
  endtask

  task automatic host_b(output logic [1:0] rsp, inout int n);
    int g;
    g = 0;
    s_if.bReady = 1'b1;
    while (!s_if.bValid && g < 100) begin
      @(negedge clk); n++; g++;
    end
    if (g >= 100) tmo("b");
    rsp = s_if.bResp;
    @(negedge clk);
    s_if.bReady = 1'b0;
  endtask

  task automatic host_r(input logic [31:0] ad, output logic [31:0] d,
                        output logic [1:0] rsp, output int n);
    bit ard;
    int g;
    ard = 0; g = 0; n = 0;
    @(negedge clk);
    s_if.arValid = 1'b1; s_if.arAddr = ad; s_if.arProt = 3'b101;
    s_if.rReady = 1'b1;
    while (!ard && g < 100) begin
      if (s_if.arValid && s_if.arReady) ard = 1;
      @(negedge clk);
      g++;
      if (ard) begin n++; s_if.arValid = 1'b0; end
    end
    while (!s_if.rValid && g < 100) begin
      @(negedge clk); n++; g++;
    end
    if (g >= 100) tmo("r");
    s_if.arValid = 1'b0;
    d = s_if.rData; rsp = s_if.rResp;
    @(negedge clk);
    s_if.rReady = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          port;
    logic [31:0] faddr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [8];
    int n, nw, nr, bad, g, vt;
    logic [1:0] rsp, brsp, rrsp;
    logic [31:0] rd;
    logic [1:0] after_w;
    bit whs_p, got;

    tv[0] = '{1, 32'h1004, 32'hDEADBEEF, 4'hF, 1, 32'h004,
              2'b00, 32'h0, 4};
    tv[1] = '{0, 32'h2008, 32'h0, 4'h0, 2, 32'h008,
              2'b00, 32'h12345678, 3};
    tv[2] = '{1, 32'h4000, 32'h55AA55AA, 4'hF, -1, 32'h0,
              2'b11, 32'h0, 2};
    tv[3] = '{0, 32'h5000, 32'h0, 4'h0, -1, 32'h0,
              2'b11, 32'h0, 1};
    tv[4] = '{1, 32'h3FFC, 32'h0000A5A5, 4'h3, 3, 32'hFFC,
              2'b10, 32'h0, 4};
    tv[5] = '{0, 32'h0ABC, 32'h0, 4'h0, 0, 32'hABC,
              2'b00, 32'hC0DE0000, 3};
    tv[6] = '{0, 32'h3FF0, 32'h0, 4'h0, 3, 32'hFF0,
              2'b10, 32'h33333333, 3};
    tv[7] = '{1, 32'hFFFFF000, 32'h1, 4'h1, -1, 32'h0,
              2'b11, 32'h0, 2};

    s_if.awValid = 1'b0; s_if.awAddr = '0; s_if.awProt = '0;
    s_if.wValid = 1'b0; s_if.wData = '0; s_if.wStrb = '0;
    s_if.bReady = 1'b0;
    s_if.arValid = 1'b0; s_if.arAddr = '0; s_if.arProt = '0;
    s_if.rReady = 1'b0;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_host", {s_if.awReady, s_if.wReady, s_if.bValid,
        s_if.arReady, s_if.rValid, s_if.bResp, s_if.rResp}, 0);
    chk("rst_rdata", s_if.rData, 0);
    chk("rst_ports", pv, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_ready", {s_if.awReady, s_if.arReady}, 2'b11);

    for (int k = 0; k < 8; k++) begin
      int a0 [4];
      logic [3:0] msk;
      for (int p = 0; p < 4; p++) a0[p] = act[p];
      rd = '0;
      if (tv[k].wr) begin
        host_aw_w(tv[k].addr, tv[k].data, tv[k].strb, n);
        host_b(rsp, n);
      end else begin
        host_r(tv[k].addr, rd, rsp, n);
      end
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_resp", k), rsp, tv[k].resp);
      chk($sformatf("v%0d_lat", k), n, tv[k].lat);
      if (!tv[k].wr) chk($sformatf("v%0d_rdata", k), rd, tv[k].rdata);
      for (int p = 0; p < 4; p++) msk[p] = (act[p] != a0[p]);
      chk($sformatf("v%0d_ports", k), msk,
          (tv[k].port >= 0) ? (4'b1 << tv[k].port) : 4'b0);
      if (tv[k].port >= 0 && tv[k].wr) begin
        chk($sformatf("v%0d_awaddr", k),
            aw_seen[tv[k].port], tv[k].faddr);
        chk($sformatf("v%0d_wdata", k),
            w_seen[tv[k].port], tv[k].data);
        chk($sformatf("v%0d_wstrb", k),
            ws_seen[tv[k].port], tv[k].strb);
        chk($sformatf("v%0d_awprot", k),
            awp_seen[tv[k].port], 3'b010);
      end else if (tv[k].port >= 0) begin
        chk($sformatf("v%0d_araddr", k),
            ar_seen[tv[k].port], tv[k].faddr);
        chk($sformatf("v%0d_arprot", k),
            arp_seen[tv[k].port], 3'b101);
      end
    end

    // write and read to port 0 issued in the same cycle
    fork
      begin
        host_aw_w(32'h0000, 32'hCAFEF00D, 4'hF, nw);
        host_b(brsp, nw);
      end
      host_r(32'h0010, rd, rrsp, nr);
    join
    chk("t4_bresp", brsp, 2'b00);
    chk("t4_wlat", nw, 4);
    chk("t4_rlat", nr, 3);
    chk("t4_rdata", {rrsp, rd}, {2'b00, 32'hC0DE0000});
    chk("t4_fwd", {aw_seen[0], w_seen[0], ar_seen[0]},
        {32'h0, 32'hCAFEF00D, 32'h10});

    // port 3 stalls AW for 5 cycles, host holds off B for 10
    aw_dly[3] = 5;
    host_aw_w(32'h3010, 32'h0BADCAFE, 4'hC, n);
    s_if.bReady = 1'b0;
    bad = 0; g = 0; whs_p = 0; got = 0; after_w = 2'bxx;
    while (!s_if.bValid && g < 60) begin
      if (whs_p && !got) begin
        after_w = {pv[3][3], pv[3][4]};
        got = 1;
      end
      whs_p = pv[3][3] && prdy[3][0];
      if (s_if.awReady) bad++;
      @(negedge clk);
      g++;
    end
    if (g >= 60) tmo("t5_b");
    chk("t5_wdrop_awheld", after_w, 2'b01);
    chk("t5_fwd", {aw_seen[3], w_seen[3], ws_seen[3]},
        {32'h010, 32'h0BADCAFE, 4'hC});
    repeat (10) begin
      if (!s_if.bValid || s_if.awReady) bad++;
      @(negedge clk);
    end
    chk("t5_hold", bad, 0);
    chk("t5_bresp", s_if.bResp, 2'b10);
    s_if.bReady = 1'b1;
    @(negedge clk);
    s_if.bReady = 1'b0;
    chk("t5_after_b", {s_if.bValid, s_if.awReady}, 2'b01);
    aw_dly[3] = 0;

    // reset while waiting for B on port 1
    hold_b[1] = 1;
    host_aw_w(32'h1000, 32'h01020304, 4'hF, n);
    @(negedge clk);
    chk("t6_bwait", pv[1], 5'b00100);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_host", {s_if.awReady, s_if.wReady, s_if.bValid,
        s_if.arReady, s_if.rValid, s_if.bResp}, 0);
    chk("t6_rst_ports", pv, 0);
    rstn = 1'b1;
    hold_b[1] = 0;
    @(negedge clk);
    chk("t6_rel_awready", s_if.awReady, 1'b1);
    bad = 0;
    repeat (5) begin
      if (s_if.bValid || (pv != '0)) bad++;
      @(negedge clk);
    end
    chk("t6_no_b", bad, 0);

    // post-reset transaction to confirm recovery
    host_r(32'h2000, rd, rsp, n);
    chk("t6_recover", {rsp, rd}, {2'b00, 32'h12345678});

    vt = viol_s;
    for (int p = 0; p < 4; p++) vt += viol[p];
    chk("valid_stable", vt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
